// File: rtl/mem_access_unit_pkg.sv
// Shared types, funct3 encodings, exception codes and lane helpers for the
// MEM-stage data-memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  // Byte-lane enables for an access of 2**size bytes at a doubleword offset.
  function automatic logic [7:0] byte_enables(input logic [1:0] size,
                                              input logic [2:0] offset);
    case (size)
      2'd0:    return 8'h01 << offset;
      2'd1:    return 8'h03 << offset;
      2'd2:    return 8'h0F << offset;
      default: return 8'hFF;
    endcase
  endfunction

  // Natural alignment check for an access of 2**size bytes.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [2:0] offset);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return offset[0];
      2'd2:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed bytes of a read doubleword and extends them to 64 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Shift the addressed byte down to lane 0, then truncate and extend by width.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   result = {56'd0, shifted[7:0]};
      F3_HU:   result = {48'd0, shifted[15:0]};
      F3_WU:   result = {32'd0, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one aligned 64-bit bus access per memory
// instruction, extends load data and stalls the front of the pipe until retire.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_v,
  input  logic                mem_load,
  input  logic                mem_store,
  input  logic [2:0]          mem_funct3,
  input  logic [63:0]         mem_alu_result,
  input  logic [63:0]         mem_sr2,
  input  logic                wb_stall,
  output logic                mem_stall,
  output logic                wb_mem_v,
  output logic [63:0]         wb_mem_result,
  output logic [1:0]          wb_mem_exc,
  output logic [63:0]         wb_mem_addr,
  mem_access_unit_if.master   dmem
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         offset_q;
  logic [2:0]         funct3_q;
  logic               load_q;

  logic               op;
  logic [2:0]         a;
  logic               illegal;
  logic [1:0]         exc_in;
  logic [63:0]        load_data;

  assign op      = mem_v & (mem_load | mem_store);
  assign a       = mem_alu_result[2:0];
  assign illegal = (mem_load & mem_store) |
                   (mem_load & (mem_funct3 == 3'b111)) |
                   (mem_store & mem_funct3[2]);
  assign exc_in  = illegal ? EXC_ILLEGAL :
                   misaligned(mem_funct3[1:0], a) ? EXC_MISALIGN : EXC_NONE;

  mem_load_align u_align (
    .rdata  (dmem.rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (load_data)
  );

  // Stall the front of the pipe while an access is being launched or is in flight.
  always_comb begin
    mem_stall = wb_stall;
    case (state)
      IDLE:    mem_stall = op | wb_stall;
      REQ:     mem_stall = 1'b1;
      default: mem_stall = wb_stall;
    endcase
  end

  // Access sequencer with registered bus and writeback outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      offset_q      <= '0;
      funct3_q      <= '0;
      load_q        <= 1'b0;
      wb_mem_v      <= 1'b0;
      wb_mem_result <= '0;
      wb_mem_exc    <= EXC_NONE;
      wb_mem_addr   <= '0;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= '0;
      dmem.be       <= '0;
      dmem.wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op && !wb_stall) begin
            wb_mem_addr <= mem_alu_result;
            offset_q    <= a;
            funct3_q    <= mem_funct3;
            load_q      <= mem_load;
            cnt         <= '0;
            if (exc_in == EXC_NONE) begin
              state      <= REQ;
              dmem.req   <= 1'b1;
              dmem.we    <= mem_store;
              dmem.addr  <= {mem_alu_result[63:3], 3'b000};
              dmem.be    <= byte_enables(mem_funct3[1:0], a);
              dmem.wdata <= mem_sr2 << {a, 3'b000};
            end else begin
              state         <= DONE;
              wb_mem_v      <= 1'b1;
              wb_mem_exc    <= exc_in;
              wb_mem_result <= '0;
            end
          end
        end
        REQ: begin
          if (dmem.ack) begin
            state         <= DONE;
            dmem.req      <= 1'b0;
            wb_mem_v      <= 1'b1;
            wb_mem_exc    <= EXC_NONE;
            wb_mem_result <= load_q ? load_data : '0;
          end else if (TIMEOUT_CYCLES != 0 &&
                       cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state         <= DONE;
            dmem.req      <= 1'b0;
            wb_mem_v      <= 1'b1;
            wb_mem_exc    <= EXC_TIMEOUT;
            wb_mem_result <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!wb_stall) begin
            state    <= IDLE;
            wb_mem_v <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit with a byte-level reference model.
module tb_mem_access_unit;

  localparam int TOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_v;
  logic        mem_load;
  logic        mem_store;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_sr2;
  logic        wb_stall;
  logic        mem_stall;
  logic        wb_mem_v;
  logic [63:0] wb_mem_result;
  logic [1:0]  wb_mem_exc;
  logic [63:0] wb_mem_addr;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_v          (mem_v),
    .mem_load       (mem_load),
    .mem_store      (mem_store),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_sr2        (mem_sr2),
    .wb_stall       (wb_stall),
    .mem_stall      (mem_stall),
    .wb_mem_v       (wb_mem_v),
    .wb_mem_result  (wb_mem_result),
    .wb_mem_exc     (wb_mem_exc),
    .wb_mem_addr    (wb_mem_addr),
    .dmem           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: computes the architectural outcome byte by byte.
  function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] sr2,
                                input logic [63:0] rd, output logic [1:0] exc,
                                output logic [63:0] res, output logic [7:0] be,
                                output logic [63:0] wd);
    int size;
    int a;
    logic [63:0] v;
    size = 1 << f3[1:0];
    a    = int'(addr[2:0]);
    if ((ld && st) || (ld && f3 == 3'd7) || (st && f3 >= 3'd4)) exc = 2'd3;
    else if (a % size != 0)                                     exc = 2'd1;
    else                                                        exc = 2'd0;
    be = 8'h00;
    for (int i = 0; i < size; i++)
      if (a + i < 8) be[a + i] = 1'b1;
    wd = sr2 << (8 * a);
    v = 64'd0;
    for (int i = 0; i < size; i++)
      if (a + i < 8) v = v | (64'(rd[8*(a+i) +: 8]) << (8 * i));
    if (f3 < 3'd4 && size < 8 && v[8*size-1])
      v = v | (~64'd0 << (8 * size));
    res = (ld && !st) ? v : 64'd0;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // One instruction through the unit; ack_dly = REQ cycles before ACK (>= TOUT never acks).
  task automatic access(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sr2,
                        input logic [63:0] rd, input int ack_dly, input int hold);
    logic [1:0]  mexc, exp_exc;
    logic [63:0] mres, exp_res, mwd, got_res;
    logic [7:0]  mbe;
    int exp_reqs, exp_stalls, stalls, reqs;
    bit got;
    model(ld, st, f3, addr, sr2, rd, mexc, mres, mbe, mwd);
    if (mexc != 2'd0) begin
      exp_exc = mexc; exp_res = 64'd0; exp_reqs = 0;
    end else if (ack_dly >= TOUT) begin
      exp_exc = 2'd2; exp_res = 64'd0; exp_reqs = TOUT;
    end else begin
      exp_exc = 2'd0; exp_res = mres; exp_reqs = ack_dly + 1;
    end
    exp_stalls = exp_reqs + 1;
    mem_v = 1'b1; mem_load = ld; mem_store = st; mem_funct3 = f3;
    mem_alu_result = addr; mem_sr2 = sr2;
    stalls = 0; reqs = 0; got = 1'b0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      #1;
      if (wb_mem_v) got = 1'b1;
      else begin
        if (mem_stall) stalls++;
        if (bus.req) begin
          if (reqs == 0) begin
            chk({tag, "/addr"}, bus.addr, {addr[63:3], 3'b000});
            chk({tag, "/we"}, 64'(bus.we), 64'(st));
            chk({tag, "/be"}, 64'(bus.be), 64'(mbe));
            chk({tag, "/wdata"}, bus.wdata & lane_mask(mbe), mwd & lane_mask(mbe));
          end
          if (reqs == ack_dly) begin bus.ack = 1'b1; bus.rdata = rd; end
          reqs++;
        end
        @(negedge clk);
        bus.ack = 1'b0;
        bus.rdata = $urandom();
      end
    end
    chk({tag, "/retired"}, 64'(got), 64'd1);
    chk({tag, "/result"}, wb_mem_result, exp_res);
    chk({tag, "/exc"}, 64'(wb_mem_exc), 64'(exp_exc));
    chk({tag, "/wbaddr"}, wb_mem_addr, addr);
    chk({tag, "/reqs"}, 64'(reqs), 64'(exp_reqs));
    chk({tag, "/stalls"}, 64'(stalls), 64'(exp_stalls));
    got_res = wb_mem_result;
    for (int k = 0; k < hold; k++) begin
      wb_stall = 1'b1;
      @(negedge clk); #1;
      chk({tag, "/hold_v"}, 64'(wb_mem_v), 64'd1);
      chk({tag, "/hold_res"}, wb_mem_result, got_res);
      chk({tag, "/hold_exc"}, 64'(wb_mem_exc), 64'(exp_exc));
      chk({tag, "/hold_stall"}, 64'(mem_stall), 64'd1);
      chk({tag, "/hold_req"}, 64'(bus.req), 64'd0);
    end
    wb_stall = 1'b0;
    #1;
    chk({tag, "/done_stall"}, 64'(mem_stall), 64'd0);
    mem_v = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit ld, st;
    logic [2:0]  f3;
    logic [63:0] addr;
    rst_n = 1'b0; mem_v = 1'b0; mem_load = 1'b0; mem_store = 1'b0; mem_funct3 = 3'd0;
    mem_alu_result = 64'd0; mem_sr2 = 64'd0; wb_stall = 1'b0;
    bus.ack = 1'b0; bus.rdata = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst/req", 64'(bus.req), 64'd0);
    chk("rst/wbv", 64'(wb_mem_v), 64'd0);
    chk("rst/res", wb_mem_result, 64'd0);
    chk("rst/exc", 64'(wb_mem_exc), 64'd0);
    chk("rst/addr", bus.addr, 64'd0);
    chk("rst/stall", 64'(mem_stall), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass-through: no op, stall follows writeback.
    wb_stall = 1'b1; #1;
    chk("pass/stall1", 64'(mem_stall), 64'd1);
    chk("pass/noreq", 64'(bus.req), 64'd0);
    wb_stall = 1'b0; #1;
    chk("pass/stall0", 64'(mem_stall), 64'd0);
    @(negedge clk);

    access("ld",    1, 0, 3'd3, 64'h1000, 64'd0, 64'h8877665544332211, 0, 0);
    access("lb",    1, 0, 3'd0, 64'h1003, 64'd0, 64'h0000000080000000, 0, 0);
    access("lbu",   1, 0, 3'd4, 64'h1003, 64'd0, 64'h0000000080000000, 1, 0);
    access("sh",    0, 1, 3'd1, 64'h2006, 64'hABCD, 64'd0, 0, 0);
    access("lw_mis",1, 0, 3'd2, 64'h3002, 64'd0, 64'd0, 0, 0);
    access("ld_ill",1, 0, 3'd7, 64'h3000, 64'd0, 64'd0, 0, 0);
    access("st_ill",0, 1, 3'd4, 64'h3003, 64'd0, 64'd0, 0, 0);
    access("ldst",  1, 1, 3'd3, 64'h3000, 64'd0, 64'd0, 0, 0);
    access("tmo",   1, 0, 3'd3, 64'h4000, 64'd0, 64'd0, 99, 0);
    access("post",  1, 0, 3'd2, 64'h4004, 64'd0, 64'hF1234567_00000000, 0, 0);
    access("hold",  1, 0, 3'd1, 64'h5002, 64'd0, 64'h00000000_9ABC0000, 2, 3);

    // Reset during REQ drops the request; a stray ACK afterwards is ignored.
    mem_v = 1'b1; mem_load = 1'b1; mem_store = 1'b0; mem_funct3 = 3'd3;
    mem_alu_result = 64'h6000;
    @(negedge clk); #1;
    chk("rstreq/req", 64'(bus.req), 64'd1);
    rst_n = 1'b0; mem_v = 1'b0;
    @(negedge clk); #1;
    chk("rstreq/dropped", 64'(bus.req), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.ack = 1'b1; bus.rdata = 64'h1111;
    @(negedge clk);
    bus.ack = 1'b0; #1;
    chk("rstreq/stray_v", 64'(wb_mem_v), 64'd0);
    chk("rstreq/stray_req", 64'(bus.req), 64'd0);
    chk("rstreq/stall", 64'(mem_stall), 64'd0);
    @(negedge clk);
    access("after_rst", 1, 0, 3'd5, 64'h6006, 64'd0, 64'h8001_0000_0000_0000, 0, 0);

    // Randomized mix of widths, offsets, kinds and ACK latencies.
    for (int n = 0; n < 40; n++) begin
      st   = ($urandom_range(0, 2) == 0);
      ld   = !st || ($urandom_range(0, 15) == 0);
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) != 0) addr[2:0] = addr[2:0] & ~3'((1 << f3[1:0]) - 1);
      access("rnd", ld, st, f3, addr, {$urandom(), $urandom()}, {$urandom(), $urandom()},
             ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 2)),
             ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
